// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// AES-128 round-key sequencer and store. Accepts a cipher key, drives the
// single-round subkey generator (GenSubKey) once per round by feeding each
// result back as the next input, and keeps all round keys 0..NUM_ROUNDS in a
// local register file that the round datapath reads by index.
//
// Optional feature macro: KEY_SCHED_TIMEOUT_EN
//   defined   -> per-round watchdog; err is raised and the FSM returns to IDLE
//                when GenSubKey does not answer within TIMEOUT_CYCLES.
//   undefined -> no watchdog, err is constant 0.
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl #(
    parameter int KEY_LEN        = 128,
    parameter int NUM_ROUNDS     = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    output logic               busy,
    output logic               keys_ready,
    output logic               err,
    output logic [3:0]         gsk_round_n,
    output logic [KEY_LEN-1:0] gsk_data_out,
    output logic               gsk_valid_out,
    input  logic [KEY_LEN-1:0] gsk_data_in,
    input  logic               gsk_valid_in,
    input  logic [3:0]         rd_round,
    output logic [KEY_LEN-1:0] rd_key
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    // Round-key store: slot 0 is the cipher key, slot r+1 the result of round r.
    logic [KEY_LEN-1:0] slot_r [0:NUM_ROUNDS];
    logic [3:0]         round_r;

    logic               busy_r;
    logic               keys_ready_r;
    logic               gsk_valid_out_r;
    logic [3:0]         gsk_round_n_r;
    logic [KEY_LEN-1:0] gsk_data_out_r;
    logic [KEY_LEN-1:0] rd_key_r;

    logic               accept_s;
    logic               wr_sub_s;
    logic               last_s;
    logic               timeout_s;

    // Decode of the events that move the sequencer and the key store.
    always_comb begin
        accept_s = 1'b0;
        wr_sub_s = 1'b0;
        last_s   = (round_r == 4'(NUM_ROUNDS - 1));
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = key_valid;
        end else begin
            accept_s = 1'b0;
        end
        if (state_r == ST_WAIT) begin
            wr_sub_s = gsk_valid_in;
        end else begin
            wr_sub_s = 1'b0;
        end
    end

`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_r;
    logic            err_r;

    // Watchdog: counts WAIT cycles, restarted by each ISSUE so every round gets a full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // The last permitted WAIT cycle without an answer ends the expansion.
    assign timeout_s = (state_r == ST_WAIT) && !gsk_valid_in &&
                       (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared only by a newly accepted key or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    // Without the watchdog the generator is trusted to answer eventually.
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: one ISSUE cycle per round, then WAIT for the generator.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (gsk_valid_in) begin
                    state_next_s = last_s ? ST_DONE : ST_ISSUE;
                end else if (timeout_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Key store, round counter and the request data held toward GenSubKey.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                slot_r[i] <= {KEY_LEN{1'b0}};
            end
            round_r        <= 4'd0;
            gsk_round_n_r  <= 4'd0;
            gsk_data_out_r <= {KEY_LEN{1'b0}};
        end else if (accept_s) begin
            slot_r[0]      <= key_in;
            round_r        <= 4'd0;
            gsk_round_n_r  <= 4'd0;
            gsk_data_out_r <= key_in;
        end else if (wr_sub_s) begin
            slot_r[round_r + 4'd1] <= gsk_data_in;
            if (!last_s) begin
                // The fresh subkey is the next round's input; preload it for ISSUE.
                round_r        <= round_r + 4'd1;
                gsk_round_n_r  <= round_r + 4'd1;
                gsk_data_out_r <= gsk_data_in;
            end else begin
                round_r        <= round_r;
                gsk_round_n_r  <= gsk_round_n_r;
                gsk_data_out_r <= gsk_data_out_r;
            end
        end else begin
            round_r        <= round_r;
            gsk_round_n_r  <= gsk_round_n_r;
            gsk_data_out_r <= gsk_data_out_r;
        end
    end

    // Status outputs registered from the next state so they align with the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r          <= 1'b0;
            keys_ready_r    <= 1'b0;
            gsk_valid_out_r <= 1'b0;
        end else begin
            busy_r          <= (state_next_s == ST_ISSUE) || (state_next_s == ST_WAIT);
            keys_ready_r    <= (state_next_s == ST_DONE);
            gsk_valid_out_r <= (state_next_s == ST_ISSUE);
        end
    end

    // Registered read port; indices past the last slot read as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_key_r <= {KEY_LEN{1'b0}};
        end else if (rd_round <= 4'(NUM_ROUNDS)) begin
            rd_key_r <= slot_r[rd_round];
        end else begin
            rd_key_r <= {KEY_LEN{1'b0}};
        end
    end

    assign busy          = busy_r;
    assign keys_ready    = keys_ready_r;
    assign gsk_valid_out = gsk_valid_out_r;
    assign gsk_round_n   = gsk_round_n_r;
    assign gsk_data_out  = gsk_data_out_r;
    assign rd_key        = rd_key_r;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Directed bench for aes_key_sched_ctrl. A behavioural single-round AES-128
// key-expansion block with latency 1 stands in for GenSubKey. Expected round
// keys are the published AES-128 expansion vectors.
// Optional: build with +define+KEY_SCHED_TIMEOUT_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] K1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    localparam logic [2047:0] SBOX_VEC = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic         busy;
    logic         keys_ready;
    logic         err;
    logic [3:0]   gsk_round_n;
    logic [127:0] gsk_data_out;
    logic         gsk_valid_out;
    logic [127:0] gsk_data_in;
    logic         gsk_valid_in;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;

    logic [7:0]   sbox_tab [0:255];
    logic         stub_v_r;
    logic [127:0] stub_d_r;
    logic         stub_mute;
    logic         spur;

    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .busy          (busy),
        .keys_ready    (keys_ready),
        .err           (err),
        .gsk_round_n   (gsk_round_n),
        .gsk_data_out  (gsk_data_out),
        .gsk_valid_out (gsk_valid_out),
        .gsk_data_in   (gsk_data_in),
        .gsk_valid_in  (gsk_valid_in),
        .rd_round      (rd_round),
        .rd_key        (rd_key)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            sbox_tab[i] = SBOX_VEC[2047 - 8*i -: 8];
        end
    end

    // One AES-128 key-expansion round (what GenSubKey computes).
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] rn);
        logic [7:0]  rc;
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        case (rn)
            4'd0: rc = 8'h01;  4'd1: rc = 8'h02;  4'd2: rc = 8'h04;  4'd3: rc = 8'h08;
            4'd4: rc = 8'h10;  4'd5: rc = 8'h20;  4'd6: rc = 8'h40;  4'd7: rc = 8'h80;
            4'd8: rc = 8'h1b;  4'd9: rc = 8'h36;  default: rc = 8'h00;
        endcase
        {w0, w1, w2, w3} = k;
        t  = {sbox_tab[w3[23:16]], sbox_tab[w3[15:8]], sbox_tab[w3[7:0]], sbox_tab[w3[31:24]]}
             ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // GenSubKey stand-in with latency 1; not reset, so in-flight answers survive a DUT reset.
    always @(posedge clk) begin
        stub_v_r <= gsk_valid_out & ~stub_mute;
        stub_d_r <= next_key(gsk_data_out, gsk_round_n);
    end

    assign gsk_valid_in = stub_v_r | spur;
    assign gsk_data_in  = spur ? JUNK : stub_d_r;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 1;
        while (!keys_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic read_key(input logic [3:0] idx, output logic [127:0] v);
        rd_round = idx;
        @(negedge clk);
        v = rd_key;
    endtask

    initial begin
        int           n;
        int           pulses;
        logic         busy_before;
        logic [127:0] v;

        reset     = 1'b1;
        key_in    = 128'h0;
        key_valid = 1'b0;
        rd_round  = 4'd0;
        stub_mute = 1'b0;
        spur      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",       128'(busy),          128'h0);
        check("rst_keys_ready", 128'(keys_ready),    128'h0);
        check("rst_err",        128'(err),           128'h0);
        check("rst_gsk_valid",  128'(gsk_valid_out), 128'h0);
        check("rst_gsk_data",   gsk_data_out,        128'h0);
        check("rst_rd_key",     rd_key,              128'h0);
        reset = 1'b0;
        @(negedge clk);

        // Scenario 1: FIPS-197 key 000102...0f.
        start_key(K1);
        wait_ready(n);
        check("k1_ready", 128'(keys_ready), 128'h1);
        read_key(4'd0, v);  check("k1_slot0",  v, K1);
        read_key(4'd1, v);  check("k1_slot1",  v, K1_R1);
        read_key(4'd10, v); check("k1_slot10", v, K1_R10);
        read_key(4'd11, v); check("rd_11_zero", v, 128'h0);
        read_key(4'd10, v);
        read_key(4'd15, v); check("rd_15_zero", v, 128'h0);

        // Scenario 2: key 2b7e..., with request sequence and timing.
        start_key(K2);
        check("k2_issue0_valid", 128'(gsk_valid_out), 128'h1);
        check("k2_issue0_busy",  128'(busy),          128'h1);
        check("k2_drop_ready",   128'(keys_ready),    128'h0);
        n = 1;
        pulses = 0;
        busy_before = 1'b0;
        while (!keys_ready && n < 200) begin
            if (gsk_valid_out) begin
                check("k2_round_n", 128'(gsk_round_n), 128'(pulses));
                pulses++;
            end
            busy_before = busy;
            @(negedge clk);
            n++;
        end
        check("k2_ready_cycle", 128'(n),           128'd21);
        check("k2_pulses",      128'(pulses),      128'd10);
        check("k2_busy_falls",  128'(busy),        128'h0);
        check("k2_busy_before", 128'(busy_before), 128'h1);
        read_key(4'd1, v);  check("k2_slot1",  v, K2_R1);
        read_key(4'd10, v); check("k2_slot10", v, K2_R10);

        // Scenario 3: spurious key_valid and gsk_valid_in while busy.
        start_key(K1);
        n = 1;
        pulses = 0;
        while (!keys_ready && n < 200) begin
            if (gsk_valid_out) begin
                pulses++;
                if (gsk_round_n == 4'd2 || gsk_round_n == 4'd6) begin
                    spur      = 1'b1;
                    key_valid = 1'b1;
                    key_in    = JUNK;
                end
            end
            @(negedge clk);
            spur      = 1'b0;
            key_valid = 1'b0;
            n++;
        end
        check("spur_ready_cycle", 128'(n),      128'd21);
        check("spur_pulses",      128'(pulses), 128'd10);
        read_key(4'd0, v);  check("spur_slot0",  v, K1);
        read_key(4'd1, v);  check("spur_slot1",  v, K1_R1);
        read_key(4'd10, v); check("spur_slot10", v, K1_R10);

        // Same-cycle update: a read issued with the accepting key_valid returns the old slot 0.
        rd_round  = 4'd0;
        key_in    = K2;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("same_cycle_old", rd_key,           K1);
        check("b2b_ready_low",  128'(keys_ready), 128'h0);
        check("b2b_busy",       128'(busy),       128'h1);
        @(negedge clk);
        check("same_cycle_new", rd_key, K2);
        wait_ready(n);
        read_key(4'd10, v); check("b2b_slot10", v, K2_R10);

        // Scenario 4: reset during round 5, then a fresh key.
        start_key(K2);
        n = 1;
        while (!(gsk_valid_out && gsk_round_n == 4'd5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_r5", 128'(gsk_round_n), 128'd5);
        reset    = 1'b1;
        rd_round = 4'd0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_busy",       128'(busy),          128'h0);
        check("mid_keys_ready", 128'(keys_ready),    128'h0);
        check("mid_err",        128'(err),           128'h0);
        check("mid_gsk_valid",  128'(gsk_valid_out), 128'h0);
        check("mid_gsk_round",  128'(gsk_round_n),   128'h0);
        check("mid_gsk_data",   gsk_data_out,        128'h0);
        @(negedge clk);
        check("mid_rd0_zero",   rd_key,              128'h0);
        check("mid_inflight",   128'(busy),          128'h0);
        read_key(4'd6, v); check("mid_rd6_zero", v, 128'h0);
        start_key(K1);
        wait_ready(n);
        check("post_ready_cycle", 128'(n), 128'd21);
        read_key(4'd1, v);  check("post_slot1",  v, K1_R1);
        read_key(4'd10, v); check("post_slot10", v, K1_R10);

`ifdef KEY_SCHED_TIMEOUT_EN
        // Watchdog: generator never answers.
        stub_mute = 1'b1;
        start_key(K2);
        n = 1;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("to_err_cycle",   128'(n),          128'd66);
        check("to_err",         128'(err),        128'h1);
        check("to_busy",        128'(busy),       128'h0);
        check("to_keys_ready",  128'(keys_ready), 128'h0);
        repeat (3) @(negedge clk);
        check("to_err_sticky",  128'(err),        128'h1);
        stub_mute = 1'b0;
        start_key(K1);
        check("to_err_cleared", 128'(err),        128'h0);
        wait_ready(n);
        read_key(4'd10, v); check("to_recover_slot10", v, K1_R10);
`else
        check("err_tied_low", 128'(err), 128'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Round-key sequencer and store for the AES-128 key path. It accepts a cipher key, drives the single-round subkey generator (`GenSubKey`) once per round by feeding back each result as the next `data_in`, and captures all 11 round keys (0..10) in a local register file. The cipher round pipeline then reads keys by round index. It sits directly upstream of `GenSubKey` and directly upstream of the round datapath.

## Interface
- `KEY_LEN`, 128, key and subkey width in bits.
- `NUM_ROUNDS`, 10, number of generated round keys; slots are 0..NUM_ROUNDS.
- `TIMEOUT_CYCLES`, 64, watchdog limit per round. Used only with `KEY_SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `key_in` in KEY_LEN: cipher key, sampled when `key_valid` is accepted.
- `key_valid` in 1: start-expansion request.
- `busy` out 1: expansion in progress.
- `keys_ready` out 1: all 11 slots are valid for the current key.
- `err` out 1: watchdog fired. Sticky until the next accepted `key_valid` or `reset`.
- `gsk_round_n` out 4: round index of the key being sent to `GenSubKey` (0..9).
- `gsk_data_out` out KEY_LEN: previous subkey sent to `GenSubKey.data_in`.
- `gsk_valid_out` out 1: one-cycle request pulse to `GenSubKey.valid_in`.
- `gsk_data_in` in KEY_LEN: from `GenSubKey.data_out`.
- `gsk_valid_in` in 1: from `GenSubKey.valid_out`.
- `rd_round` in 4: read index.
- `rd_key` out KEY_LEN: registered read data.

## Operation
- **Reset.**
  - All outputs are 0.
  - All 11 slots are cleared.
  - State goes to IDLE and the round counter to 0.
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE / DONE.**
  - `key_valid` high: write `key_in` to slot 0, set the round counter `r` to 0, clear `keys_ready` and `err`, and go to ISSUE.
  - Otherwise stay in the current state.
- **ISSUE.**
  - `gsk_valid_out` = 1, `gsk_data_out` = slot[r], `gsk_round_n` = r.
  - Go to WAIT next cycle. ISSUE always lasts exactly one cycle.
- **WAIT.**
  - `gsk_valid_out` = 0. `gsk_data_out` and `gsk_round_n` hold their values.
  - On `gsk_valid_in`, write `gsk_data_in` to slot[r+1].
  - If r = NUM_ROUNDS-1, go to DONE. Otherwise r increments and the state returns to ISSUE.
- **Status outputs.**
  - `busy` = 1 in ISSUE and WAIT.
  - `keys_ready` = 1 in DONE only.
- **Ignored inputs.**
  - `key_valid` is ignored in ISSUE and WAIT; there is no abort.
  - `gsk_valid_in` is ignored outside WAIT.
- **Read port.**
  - `rd_key` is registered from slot[`rd_round`].
  - `rd_round` > NUM_ROUNDS returns 0.
  - Reads are legal at any time. During expansion, unwritten slots return stale or cleared contents; consumers gate on `keys_ready`.
- **Same-cycle update.** When `key_valid` is accepted in DONE, slot 0 updates on that edge. A read issued in the same cycle returns the old slot 0.
- **Reset mid-expansion:** returns to IDLE with all slots cleared. Any in-flight `GenSubKey` result arriving afterwards is ignored.

## Timing
- Let k ≥ 1 be the `GenSubKey` latency: the number of cycles from the `gsk_valid_out` cycle to the `gsk_valid_in` cycle.
- Each round takes k+1 cycles (ISSUE + k WAIT cycles).
- With `key_valid` sampled at edge 0:
  - ISSUE for round 0 occupies cycle 1.
  - `keys_ready` is first high in cycle 10(k+1)+1. For k=1 that is cycle 21.
- `busy` rises in cycle 1 and falls in the same cycle `keys_ready` rises.
- Read latency is 1 cycle: `rd_round` presented in cycle n gives `rd_key` valid in cycle n+1.
- Back-to-back keys: `key_valid` in DONE drops `keys_ready` in the next cycle and restarts at ISSUE.

## Configuration
- **`KEY_SCHED_TIMEOUT_EN` defined:**
  - A counter runs in WAIT, cleared on entry to WAIT.
  - If `gsk_valid_in` has not arrived after TIMEOUT_CYCLES WAIT cycles, set `err` = 1, clear `busy`, and go to IDLE. `keys_ready` stays 0.
- **Not defined:**
  - No counter; `err` is tied to 0.
  - WAIT lasts until `gsk_valid_in` arrives.

## Test plan
- Instance real `GenSubKey` and apply `key_in` = 000102030405060708090a0b0c0d0e0f with a `key_valid` pulse.
  - After `keys_ready`, `rd_round`=1 → d6aa74fdd2af72fadaa678f1d6ab76fe.
  - `rd_round`=10 → 13111d7fe3944a17f307a78b4d2b30c5.
- Apply key 2b7e151628aed2a6abf7158809cf4f3c.
  - `rd_round`=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `gsk_valid_out` pulses exactly 10 times with `gsk_round_n` 0..9.
  - `keys_ready` rises at cycle 10(k+1)+1.
- Pulse `key_valid` and spurious `gsk_valid_in` while `busy`.
  - Slot contents and round count are unaffected.
  - Final keys match the first scenario.
- Assert `reset` during round 5, then start a new key.
  - Immediately after reset, all outputs are 0 and `rd_round`=0 → 0.
  - The new key expands correctly.
- Read with `rd_round`=11 and 15 → `rd_key` = 0.
- With `KEY_SCHED_TIMEOUT_EN` defined and a stub that never returns `gsk_valid_in`:
  - `err`=1 after 64 WAIT cycles, `busy`=0, `keys_ready`=0.
  - A new `key_valid` clears `err`.
